// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-paced tick generator with score, level, lives and death/respawn/over/won sequencing
module game_flow_ctrl #(
    parameter int SCORE_W          = 8,
    parameter int LIVES            = 3,
    parameter int LEVELS           = 8,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int BASE_FRAMES      = 16,
    parameter int FRAME_STEP       = 2,
    parameter int DEATH_FRAMES     = 60
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_restart,
    input  logic                        i_pause,
    input  logic                        i_start,
    input  logic                        i_vsync,
    input  logic                        i_tick_done,
    input  logic                        i_ready,
    input  logic                        i_eat,
    input  logic                        i_failure,
    input  logic                        i_success,
    output logic                        o_tick,
    output logic                        o_game_rst_n,
    output logic [2:0]                  o_state,
    output logic [SCORE_W-1:0]          o_score,
    output logic [$clog2(LIVES+1)-1:0]  o_lives,
    output logic [$clog2(LEVELS)-1:0]   o_level,
    output logic                        o_failure,
    output logic                        o_success,
    output logic                        o_flash
);
    typedef enum logic [2:0] {IDLE, RUN, DYING, RESPAWN, OVER, WON} state_t;
    localparam int LW   = $clog2(LIVES + 1);
    localparam int VW   = $clog2(LEVELS);
    localparam int AW   = $clog2(APPLES_PER_LEVEL + 1);
    localparam int FMAX = BASE_FRAMES > DEATH_FRAMES ? BASE_FRAMES : DEATH_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic [VW-1:0]      level_q, level_d;
    logic [AW-1:0]      acnt_q, acnt_d;
    logic [FW-1:0]      fc_q, fc_d;
    logic               pend_q, pend_d;
    logic               tick_q, tick_d;
    logic [31:0]        red, period;
    logic               wrap;
    // tick period shrinks with level, clamped at one frame without underflow
    always_comb begin
        red    = 32'(level_q) * 32'(FRAME_STEP);
        period = (32'(BASE_FRAMES) > red) ? 32'(BASE_FRAMES) - red : 32'd1;
        wrap   = 32'(fc_q) >= period - 32'd1;
    end
    // next-state: game FSM, frame counting, tick issue, score and level bookkeeping
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        level_d = level_q;
        acnt_d  = acnt_q;
        fc_d    = fc_q;
        pend_d  = pend_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                fc_d    = '0;
                state_d = i_start ? RUN : IDLE;
            end
            RUN: begin
                if (i_vsync && !i_pause) begin
                    fc_d   = wrap ? '0 : fc_q + FW'(1);
                    pend_d = pend_q | wrap;
                end
                tick_d = pend_q && i_tick_done && i_ready && !i_pause;
                if (tick_d) pend_d = 1'b0;
                if (i_eat) begin
                    score_d = &score_q ? score_q : score_q + SCORE_W'(1);
                    acnt_d  = (acnt_q == AW'(APPLES_PER_LEVEL - 1)) ? '0 : acnt_q + AW'(1);
                    if (acnt_q == AW'(APPLES_PER_LEVEL - 1))
                        level_d = (level_q == VW'(LEVELS - 1)) ? level_q : level_q + VW'(1);
                end
                if (i_failure) begin
                    lives_d = lives_q - LW'(1);
                    state_d = (lives_q == LW'(1)) ? OVER : DYING;
                    fc_d    = '0;
                    pend_d  = 1'b0;
                end else if (i_success) begin
                    state_d = WON;
                end
            end
            DYING: begin
                if (i_vsync) begin
                    fc_d    = (fc_q == FW'(DEATH_FRAMES - 1)) ? '0 : fc_q + FW'(1);
                    state_d = (fc_q == FW'(DEATH_FRAMES - 1)) ? RESPAWN : DYING;
                end
            end
            RESPAWN: state_d = IDLE;
            default: state_d = state_q;
        endcase
    end
    // state registers; restart clears all game state exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_n || i_restart) begin
            state_q <= IDLE;
            score_q <= '0;
            lives_q <= LW'(LIVES);
            level_q <= '0;
            acnt_q  <= '0;
            fc_q    <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            level_q <= level_d;
            acnt_q  <= acnt_d;
            fc_q    <= fc_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
        end
    end
    assign o_tick       = tick_q;
    assign o_game_rst_n = rst_n && !i_restart && state_q != RESPAWN;
    assign o_state      = state_q;
    assign o_score      = score_q;
    assign o_lives      = lives_q;
    assign o_level      = level_q;
    assign o_failure    = state_q == OVER;
    assign o_success    = state_q == WON;
    assign o_flash      = state_q == DYING && fc_q[2];
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed-step bench for game_flow_ctrl with default parameters
module tb_game_flow_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_restart = 1'b0, i_pause = 1'b0, i_start = 1'b0, i_vsync = 1'b0;
    logic       i_tick_done = 1'b0, i_ready = 1'b0, i_eat = 1'b0, i_failure = 1'b0, i_success = 1'b0;
    logic       o_tick, o_game_rst_n, o_failure, o_success, o_flash;
    logic [2:0] o_state;
    logic [7:0] o_score;
    logic [1:0] o_lives;
    logic [2:0] o_level;
    int         total = 0, bad = 0, ticks = 0, t0 = 0;

    game_flow_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_restart(i_restart), .i_pause(i_pause), .i_start(i_start),
        .i_vsync(i_vsync), .i_tick_done(i_tick_done), .i_ready(i_ready), .i_eat(i_eat),
        .i_failure(i_failure), .i_success(i_success), .o_tick(o_tick), .o_game_rst_n(o_game_rst_n),
        .o_state(o_state), .o_score(o_score), .o_lives(o_lives), .o_level(o_level),
        .o_failure(o_failure), .o_success(o_success), .o_flash(o_flash)
    );

    always #5 clk = ~clk;

    // count every issued tick, sampled away from the active edge
    always @(negedge clk) if (o_tick === 1'b1) ticks <= ticks + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mark();
        #1 t0 = ticks;
    endtask

    task automatic tchk(input string tag, input int exp);
        #1 chk(tag, 32'(ticks - t0), 32'(exp));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs(input int n);
        repeat (n) begin
            i_vsync = 1'b1;
            @(negedge clk);
            i_vsync = 1'b0;
            cyc(19);
        end
    endtask

    task automatic eat(input int n);
        repeat (n) begin
            i_eat = 1'b1;
            @(negedge clk);
            i_eat = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic fail();
        i_failure = 1'b1;
        @(negedge clk);
        i_failure = 1'b0;
    endtask

    task automatic start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_state", o_state, 0);
        chk("rst_score", o_score, 0);
        chk("rst_lives", o_lives, 3);
        chk("rst_level", o_level, 0);
        chk("rst_tick", o_tick, 0);
        chk("rst_game_rst_n", o_game_rst_n, 0);
        rst_n = 1'b1;
        cyc(1);
        chk("idle_game_rst_n", o_game_rst_n, 1);
        vs(3);
        chk("idle_ignores_vsync", o_state, 0);
        i_tick_done = 1'b1;
        i_ready = 1'b1;
        start();
        chk("run_state", o_state, 1);
        mark();
        vs(15);
        tchk("no_tick_before_16", 0);
        i_vsync = 1'b1;
        @(negedge clk);
        i_vsync = 1'b0;
        chk("tick_latency_0", o_tick, 0);
        @(negedge clk);
        chk("tick_latency_1", o_tick, 1);
        @(negedge clk);
        chk("tick_one_cycle", o_tick, 0);
        cyc(17);
        mark();
        vs(15);
        tchk("period16_early", 0);
        vs(1);
        tchk("period16_tick", 1);
        eat(4);
        chk("score4", o_score, 4);
        chk("level1", o_level, 1);
        mark();
        vs(13);
        tchk("period14_early", 0);
        vs(1);
        tchk("period14_tick", 1);
        eat(24);
        chk("score28", o_score, 28);
        chk("level7", o_level, 7);
        mark();
        vs(1);
        tchk("period2_early", 0);
        vs(1);
        tchk("period2_tick", 1);
        eat(4);
        chk("score32", o_score, 32);
        chk("level_sat", o_level, 7);
        i_tick_done = 1'b0;
        mark();
        vs(4);
        tchk("blocked_no_tick", 0);
        i_tick_done = 1'b1;
        cyc(3);
        tchk("no_queueing", 1);
        mark();
        i_pause = 1'b1;
        vs(51);
        tchk("pause_no_tick", 0);
        i_pause = 1'b0;
        cyc(3);
        tchk("pause_no_pending", 0);
        vs(1);
        tchk("pause_frozen_early", 0);
        vs(1);
        tchk("pause_resume_tick", 1);
        fail();
        chk("die_state", o_state, 2);
        chk("die_lives", o_lives, 2);
        chk("die_flash0", o_flash, 0);
        vs(4);
        chk("flash_on", o_flash, 1);
        vs(4);
        chk("flash_off", o_flash, 0);
        i_pause = 1'b1;
        vs(51);
        i_pause = 1'b0;
        chk("dying_59", o_state, 2);
        i_vsync = 1'b1;
        @(negedge clk);
        i_vsync = 1'b0;
        chk("respawn_state", o_state, 3);
        chk("respawn_rst_n", o_game_rst_n, 0);
        @(negedge clk);
        chk("respawn_to_idle", o_state, 0);
        chk("idle_rst_n", o_game_rst_n, 1);
        chk("score_kept", o_score, 32);
        chk("level_kept", o_level, 7);
        chk("lives_kept", o_lives, 2);
        start();
        fail();
        chk("die2_lives", o_lives, 1);
        vs(60);
        chk("die2_idle", o_state, 0);
        start();
        fail();
        chk("over_state", o_state, 4);
        chk("over_flag", o_failure, 1);
        chk("over_lives", o_lives, 0);
        i_start = 1'b1;
        eat(1);
        vs(2);
        i_start = 1'b0;
        chk("over_sticky", o_state, 4);
        chk("over_score", o_score, 32);
        chk("over_lives2", o_lives, 0);
        i_restart = 1'b1;
        @(negedge clk);
        chk("restart_rst_n", o_game_rst_n, 0);
        chk("restart_state", o_state, 0);
        chk("restart_score", o_score, 0);
        chk("restart_lives", o_lives, 3);
        chk("restart_level", o_level, 0);
        i_restart = 1'b0;
        @(negedge clk);
        start();
        i_eat = 1'b1;
        i_failure = 1'b1;
        i_success = 1'b1;
        @(negedge clk);
        i_eat = 1'b0;
        i_failure = 1'b0;
        i_success = 1'b0;
        chk("fail_wins_state", o_state, 2);
        chk("fail_wins_lives", o_lives, 2);
        chk("eat_with_fail", o_score, 1);
        vs(5);
        chk("flash_mid_dying", o_flash, 1);
        i_restart = 1'b1;
        @(negedge clk);
        i_restart = 1'b0;
        chk("dying_restart_state", o_state, 0);
        chk("dying_restart_flash", o_flash, 0);
        chk("dying_restart_lives", o_lives, 3);
        chk("dying_restart_score", o_score, 0);
        chk("dying_restart_tick", o_tick, 0);
        @(negedge clk);
        start();
        i_success = 1'b1;
        @(negedge clk);
        i_success = 1'b0;
        chk("won_state", o_state, 5);
        chk("won_flag", o_success, 1);
        fail();
        chk("won_sticky", o_state, 5);
        chk("won_lives", o_lives, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised game-flow controller, the successor of the fixed single-life tick and failure logic in the snake top level. It generates game ticks from vsync frame pulses with a speed that rises with score. It also tracks score, level and multiple lives, and sequences death, respawn, game-over and win states. It sits between tickgen-style inputs (vsync, pause, restart), the snake/apple engines and the VGA status inputs.

Parameters:
SCORE_W, 8, score counter width; saturates at 2^SCORE_W-1
LIVES, 3, lives at game start (>=1)
LEVELS, 8, number of speed levels (level 0..LEVELS-1)
APPLES_PER_LEVEL, 4, apples eaten per level increase
BASE_FRAMES, 16, vsync frames per tick at level 0
FRAME_STEP, 2, frames removed from the tick period per level
DEATH_FRAMES, 60, vsync frames spent in DYING

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_restart  in  1  level; full game restart, same effect as reset on all game state
i_pause  in  1  level; freezes frame counting and tick issue
i_start  in  1  level; player has given first input
i_vsync  in  1  one-cycle frame pulse
i_tick_done  in  1  snake engine can accept a tick
i_ready  in  1  apple engine ready
i_eat  in  1  one-cycle apple-eaten pulse
i_failure  in  1  one-cycle collision pulse
i_success  in  1  one-cycle board-full pulse
o_tick  out  1  one-cycle game tick
o_game_rst_n  out  1  active-low reset to snake/apple/control
o_state  out  3  IDLE=0 RUN=1 DYING=2 RESPAWN=3 OVER=4 WON=5
o_score  out  SCORE_W  apples eaten
o_lives  out  $clog2(LIVES+1)  remaining lives
o_level  out  $clog2(LEVELS)  current speed level
o_failure  out  1  state==OVER
o_success  out  1  state==WON
o_flash  out  1  death-flash strobe

Behaviour:
- Reset (rst_n=0 or i_restart=1 at a clock edge):
  - state IDLE, score 0, lives LIVES, level 0.
  - frame counter 0, tick_pending 0, apple counter 0, o_tick 0.
- o_game_rst_n = rst_n && !i_restart && state!=RESPAWN. This is combinational.
- Tick period P = max(1, BASE_FRAMES - level*FRAME_STEP). Compute it without underflow.
- Frame counter:
  - Counts i_vsync pulses only in RUN with i_pause=0.
  - On the vsync where the counter equals P-1: counter wraps to 0 and tick_pending is set.
  - If tick_pending is already set, the new tick is dropped; pending stays 1 and there is no queueing.
- o_tick (registered) is asserted for one cycle when state==RUN && tick_pending && i_tick_done && i_ready && !i_pause.
  - tick_pending clears in the same cycle.
  - The latency from the qualifying condition to o_tick is 1 cycle.
- i_eat in RUN:
  - score += 1, saturating.
  - Apple counter += 1. When it reaches APPLES_PER_LEVEL it resets to 0 and level += 1, saturating at LEVELS-1.
  - A changed level takes effect for the next period comparison. The frame counter is not cleared; if counter >= new P-1, the next vsync wraps.
- FSM:
  - IDLE: frame counter held 0. i_start=1 -> RUN.
  - RUN, i_failure=1: lives -= 1. If the result is 0 -> OVER, else -> DYING. Frame counter cleared; tick_pending cleared.
  - RUN, i_success=1 -> WON.
  - i_failure and i_success in the same cycle: failure wins.
  - i_eat together with i_failure: score and level update, then the failure transition.
  - DYING: counts vsyncs (pause ignored). On the DEATH_FRAMES-th vsync -> RESPAWN.
  - o_flash = frame counter bit 2 in DYING, else 0.
  - RESPAWN: exactly 1 cycle, o_game_rst_n=0, then -> IDLE. Score, level and lives are retained.
  - OVER, WON: terminal; only reset or i_restart exits.
- i_eat, i_failure and i_success outside RUN are ignored.
- i_pause in IDLE, DYING, OVER and WON has no effect.
- Reset or restart mid-DYING or mid-RESPAWN returns to IDLE with full game state reset; no tick or flash is emitted.

Test Plan:
- Default params; reset, i_start=1, i_tick_done=i_ready=1, vsync every 20 clk -> first o_tick 1 cycle after the 16th vsync; thereafter one tick per 16 vsyncs; o_state=1.
- 4 i_eat pulses -> o_score=4, o_level=1, tick period 14 vsyncs; 28 eats -> level 7 and period 2; further eats keep level 7.
- i_tick_done=0 across two period boundaries, then 1 -> exactly one o_tick; pause held 50 vsyncs -> no ticks, frame count frozen; tick resumes on schedule after release.
- i_failure in RUN -> o_lives=2, o_state=2; o_flash toggles every 4 vsyncs; after 60 vsyncs o_state=3 for 1 cycle with o_game_rst_n=0, then o_state=0; score retained.
- Three failures -> o_state=4, o_failure=1, o_lives=0; further i_start, i_eat and i_vsync give no change.
- i_failure and i_success in the same cycle -> failure path. i_success alone -> o_state=5, o_success=1. i_restart -> o_state=0, score 0, lives 3, level 0.
